// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_muldiv
//  Purpose  : MIPS32 execute stage: operand forwarding, immediate select,
//             single-cycle ALU and an iterative multiply/divide unit with HI/LO.
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_ex_valid,
    input  logic [31:0]           id_ex_instr,
    input  logic [DATA_WIDTH-1:0] reg1,
    input  logic [DATA_WIDTH-1:0] reg2,
    input  logic [DATA_WIDTH-1:0] id_ex_imm_value,
    input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_wb_write_back_result,
    input  logic                  id_ex_alu_src,
    input  logic [1:0]            id_ex_alu_op,
    input  logic [1:0]            Forward_A,
    input  logic [1:0]            Forward_B,
    output logic [DATA_WIDTH-1:0] alu_in2_out,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  ex_stall,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int             c_CW    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CW-1:0] c_CNT_W = c_CW'(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_CNT_1 = c_CW'(1);
    localparam logic [1:0]     c_IDLE  = 2'd0;
    localparam logic [1:0]     c_BUSY  = 2'd1;
    localparam logic [1:0]     c_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_acc, r_mq, r_mcand, r_hi, r_lo;
    logic                  r_is_div, r_neg_q, r_neg_r, r_div0;

    logic [DATA_WIDTH-1:0] w_op_a, w_fwd_b, w_op_b, w_alu;
    logic [5:0]            w_funct;
    logic                  w_is_r, w_md_op, w_issue, w_signed, w_mt_hi, w_mt_lo;
    logic                  w_unused;

    assign w_funct  = id_ex_instr[5:0];
    assign w_unused = ^id_ex_instr[31:6];
    assign w_is_r   = (id_ex_alu_op == 2'b10);
    assign w_md_op  = w_is_r && (w_funct[5:2] == 4'b0110);
    assign w_signed = ~w_funct[0];
    assign w_issue  = id_ex_valid && w_md_op && (r_state == c_IDLE);
    assign ex_stall = ~reset && (w_issue || (r_state == c_BUSY));
    assign w_mt_hi  = id_ex_valid && w_is_r && (w_funct == 6'h11) && !ex_stall && (r_state == c_IDLE);
    assign w_mt_lo  = id_ex_valid && w_is_r && (w_funct == 6'h13) && !ex_stall && (r_state == c_IDLE);

    always_comb begin
        case (Forward_A)
            2'b00:   w_op_a = reg1;
            2'b01:   w_op_a = mem_wb_write_back_result;
            2'b10:   w_op_a = ex_mem_alu_result;
            default: w_op_a = '0;
        endcase
        case (Forward_B)
            2'b00:   w_fwd_b = reg2;
            2'b01:   w_fwd_b = mem_wb_write_back_result;
            2'b10:   w_fwd_b = ex_mem_alu_result;
            default: w_fwd_b = '0;
        endcase
    end

    assign alu_in2_out = w_fwd_b;
    assign w_op_b      = id_ex_alu_src ? id_ex_imm_value : w_fwd_b;

    always_comb begin
        w_alu = '0;
        case (id_ex_alu_op)
            2'b00: w_alu = w_op_a + w_op_b;
            2'b01: w_alu = w_op_a - w_op_b;
            2'b11: w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: begin
                case (w_funct)
                    6'h20, 6'h21: w_alu = w_op_a + w_op_b;
                    6'h22, 6'h23: w_alu = w_op_a - w_op_b;
                    6'h24: w_alu = w_op_a & w_op_b;
                    6'h25: w_alu = w_op_a | w_op_b;
                    6'h26: w_alu = w_op_a ^ w_op_b;
                    6'h27: w_alu = ~(w_op_a | w_op_b);
                    6'h2A: w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
                    6'h2B: w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
                    6'h10: w_alu = r_hi;
                    6'h12: w_alu = r_lo;
                    default: w_alu = '0;
                endcase
            end
        endcase
    end

    assign alu_result = w_alu;
    assign hi_out     = r_hi;
    assign lo_out     = r_lo;

    // Operands are latched as magnitudes; signs are reapplied on the final step.
    logic                  w_a_neg, w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = w_signed && w_op_a[DATA_WIDTH-1];
    assign w_b_neg = w_signed && w_fwd_b[DATA_WIDTH-1];
    assign w_a_mag = w_a_neg ? -w_op_a : w_op_a;
    assign w_b_mag = w_b_neg ? -w_fwd_b : w_fwd_b;

    logic [DATA_WIDTH:0]     w_mul_sum, w_shift;
    logic [DATA_WIDTH-1:0]   w_trial, w_acc_nx, w_mq_nx, w_quo, w_rem;
    logic                    w_ge;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
    assign w_shift   = {r_acc, r_mq[DATA_WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_mcand});
    assign w_trial   = w_shift[DATA_WIDTH-1:0] - r_mcand;

    always_comb begin
        if (r_is_div) begin
            w_acc_nx = w_ge ? w_trial : w_shift[DATA_WIDTH-1:0];
            w_mq_nx  = {r_mq[DATA_WIDTH-2:0], w_ge};
        end else begin
            w_acc_nx = w_mul_sum[DATA_WIDTH:1];
            w_mq_nx  = {w_mul_sum[0], r_mq[DATA_WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -{w_acc_nx, w_mq_nx} : {w_acc_nx, w_mq_nx};
    assign w_quo  = r_div0 ? '1 : (r_neg_q ? -w_mq_nx : w_mq_nx);
    assign w_rem  = r_neg_r ? -w_acc_nx : w_acc_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_issue) begin
                        r_state  <= c_BUSY;
                        r_cnt    <= c_CNT_W;
                        r_acc    <= '0;
                        r_is_div <= w_funct[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= w_funct[1] && (w_fwd_b == '0);
                        r_mq     <= w_funct[1] ? w_a_mag : w_b_mag;
                        r_mcand  <= w_funct[1] ? w_b_mag : w_a_mag;
                    end
                    if (w_mt_hi) r_hi <= w_op_a;
                    if (w_mt_lo) r_lo <= w_op_a;
                end
                c_BUSY: begin
                    r_acc <= w_acc_nx;
                    r_mq  <= w_mq_nx;
                    r_cnt <= r_cnt - c_CNT_1;
                    if (r_cnt == c_CNT_1) begin
                        r_state <= c_DONE;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_lo <= w_prod[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage_muldiv
//  Purpose  : Self-checking bench for ex_stage_muldiv (W=32 and W=16 instances)
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid, alu_src;
    logic [31:0] instr, reg1, reg2, imm, exm, mwb;
    logic [1:0]  alu_op, fa, fb;
    logic [31:0] in2, res, hi, lo;
    logic        stall;

    logic        valid16;
    logic [31:0] instr16;
    logic [15:0] r1_16, r2_16, in2_16, res16, hi16, lo16;
    logic        stall16;

    ex_stage_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .id_ex_valid(valid), .id_ex_instr(instr),
        .reg1(reg1), .reg2(reg2), .id_ex_imm_value(imm),
        .ex_mem_alu_result(exm), .mem_wb_write_back_result(mwb),
        .id_ex_alu_src(alu_src), .id_ex_alu_op(alu_op),
        .Forward_A(fa), .Forward_B(fb), .alu_in2_out(in2), .alu_result(res),
        .ex_stall(stall), .hi_out(hi), .lo_out(lo)
    );

    ex_stage_muldiv #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .id_ex_valid(valid16), .id_ex_instr(instr16),
        .reg1(r1_16), .reg2(r2_16), .id_ex_imm_value(16'h0),
        .ex_mem_alu_result(16'h0), .mem_wb_write_back_result(16'h0),
        .id_ex_alu_src(1'b0), .id_ex_alu_op(2'b10),
        .Forward_A(2'b00), .Forward_B(2'b00), .alu_in2_out(in2_16), .alu_result(res16),
        .ex_stall(stall16), .hi_out(hi16), .lo_out(lo16)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;
    logic [5:0]  flist [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h10, 6'h12, 6'h11, 6'h13, 6'h3F, 6'h00};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] m, input logic [31:0] e);
        return (s == 2'd0) ? r : (s == 2'd1) ? m : (s == 2'd2) ? e : 32'd0;
    endfunction

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [5:0] fn,
                                              input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        if (op == 2'd3) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Reference results from plain 64-bit arithmetic.
    task automatic md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!fn[1]) begin
            if (!fn[0]) p = sa * sb;
            else        p = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
        end else if (!fn[0]) begin
            q = sa / sb;
            r = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; alu_op = 2'b10; instr = {26'($urandom), fn};
        reg1 = a; reg2 = b; fa = 2'd0; fb = 2'd0; alu_src = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n;
        md_model(fn, a, b, eh, el);
        set_r(fn, a, b);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            reg1 = $urandom; reg2 = $urandom; fa = 2'($urandom); fb = 2'($urandom);
            valid = 1'($urandom);
            #1;
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        m_hi = eh; m_lo = el;
        tick();
        set_r(6'h12, 32'd0, 32'd0);
        #1;
        chk({tag, "_mflo"}, 64'(res), 64'(m_lo));
        chk({tag, "_idle_stall"}, 64'(stall), 64'd0);
    endtask

    logic [31:0] a, bf, b, e;
    logic [5:0]  fn;
    int          n16;

    initial begin
        reset = 1'b1; alu_src = 1'b0; imm = '0; exm = '0; mwb = '0; fa = '0; fb = '0;
        set_r(6'h18, 32'd3, 32'd4);
        valid16 = 1'b0; instr16 = '0; r1_16 = '0; r2_16 = '0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("reset_stall_forced", 64'(stall), 64'd0);
        tick();
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        tick();
        valid = 1'b0;
        reset = 1'b0;
        tick();

        // Forwarded add with immediate
        valid = 1'b1; alu_op = 2'b00; reg1 = 32'd1; exm = 32'h10; fa = 2'b10;
        imm = 32'd5; alu_src = 1'b1; fb = 2'b01; mwb = 32'hCAFE_0001;
        #1;
        chk("fwd_add", 64'(res), 64'h15);
        chk("fwd_add_stall", 64'(stall), 64'd0);
        chk("fwd_b_store", 64'(in2), 64'hCAFE_0001);
        tick();

        run_md("mult_neg", 6'h18, -32'sd3, 32'd5);
        run_md("divu_100_7", 6'h1B, 32'd100, 32'd7);
        run_md("div_m7_2", 6'h1A, -32'sd7, 32'd2);
        run_md("div_mn_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("divu_by0", 6'h1B, 32'h1234, 32'd0);
        run_md("div_neg_by0", 6'h1A, 32'hFFFF_FF00, 32'd0);

        // Preload HI/LO, then reset on the 10th BUSY cycle of a MULT
        set_r(6'h11, 32'hAAAA_5555, 32'd0);
        #1;
        chk("mthi_result", 64'(res), 64'd0);
        tick();
        set_r(6'h13, 32'h1357_9BDF, 32'd0);
        tick();
        chk("mthi_hi", 64'(hi), 64'hAAAA_5555);
        chk("mtlo_lo", 64'(lo), 64'h1357_9BDF);
        set_r(6'h18, 32'd123, 32'd456);
        tick();
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("reset_busy_stall", 64'(stall), 64'd0);
        tick();
        reset = 1'b0; valid = 1'b0;
        #1;
        chk("post_reset_stall", 64'(stall), 64'd0);
        chk("post_reset_hi", 64'(hi), 64'd0);
        chk("post_reset_lo", 64'(lo), 64'd0);
        m_hi = '0; m_lo = '0;
        run_md("multu_7_6", 6'h19, 32'd7, 32'd6);

        // Random single-cycle ALU traffic including MFHI/MFLO/MTHI/MTLO
        for (int i = 0; i < 40; i++) begin
            alu_op = 2'($urandom); fn = flist[$urandom_range(15, 0)];
            valid = 1'($urandom); instr = {26'($urandom), fn};
            reg1 = $urandom; reg2 = ($urandom_range(3, 0) == 0) ? reg1 : $urandom;
            imm = $urandom; exm = $urandom; mwb = $urandom;
            fa = 2'($urandom); fb = 2'($urandom); alu_src = 1'($urandom);
            a  = fwd(fa, reg1, mwb, exm);
            bf = fwd(fb, reg2, mwb, exm);
            b  = alu_src ? imm : bf;
            e  = alu_model(alu_op, fn, a, b);
            #1;
            chk($sformatf("rnd_alu_%0d", i), 64'(res), 64'(e));
            chk($sformatf("rnd_in2_%0d", i), 64'(in2), 64'(bf));
            chk($sformatf("rnd_stall_%0d", i), 64'(stall), 64'd0);
            tick();
            if (valid && alu_op == 2'b10 && fn == 6'h11) m_hi = a;
            if (valid && alu_op == 2'b10 && fn == 6'h13) m_lo = a;
            chk($sformatf("rnd_hi_%0d", i), 64'(hi), 64'(m_hi));
            chk($sformatf("rnd_lo_%0d", i), 64'(lo), 64'(m_lo));
        end

        // Random multiply/divide operations
        for (int i = 0; i < 12; i++) begin
            fn = 6'h18 + 6'($urandom_range(3, 0));
            a  = ($urandom_range(3, 0) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(4, 0) == 0) ? 32'd0 :
                 ($urandom_range(2, 0) == 0) ? 32'($urandom_range(50, 1)) : $urandom;
            run_md($sformatf("rnd_md_%0d", i), fn, a, b);
        end

        // 16-bit instance: MULTU 0xFFFF * 0xFFFF
        valid16 = 1'b1; instr16 = 32'h0000_0019; r1_16 = 16'hFFFF; r2_16 = 16'hFFFF;
        #1;
        n16 = 0;
        while (stall16 && n16 < 100) begin
            n16++;
            tick();
        end
        valid16 = 1'b0;
        chk("w16_stall_cycles", 64'(n16), 64'd17);
        chk("w16_hi", 64'(hi16), 64'hFFFE);
        chk("w16_lo", 64'(lo16), 64'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
